jbi_rdmard_rcv: RTL and testbench

//  JBI-side receiver for the L2 RDMA-read return stream driven by the scbuf
//  (ctag_vld / 32-bit data / ue_err). Captures the ctag cycle, assembles the

---
 rtl/jbi_rdmard_rcv_if.sv | 30 +++
 rtl/jbi_rdmard_rcv.sv | 114 +++++++++++
 tb/tb_jbi_rdmard_rcv.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/jbi_rdmard_rcv_if.sv
// scbuf return stream plus buffered line handshake toward the DMA return logic.
// master drives the scbuf stream and consumes lines; slave is the receiver.
interface jbi_rdmard_rcv_if #(
  parameter int NUM_WORDS = 16
);
  logic                      scbuf_jbi_ctag_vld;
  logic [31:0]               scbuf_jbi_data;
  logic                      scbuf_jbi_ue_err;
  logic                      rcv_line_vld;
  logic                      rcv_line_rdy;
  logic [14:0]               rcv_line_ctag;
  logic [32*NUM_WORDS-1:0]   rcv_line_data;
  logic                      rcv_line_ue;
  logic                      rcv_ovf_err;
  logic                      rcv_proto_err;

  modport master (
    output scbuf_jbi_ctag_vld, scbuf_jbi_data, scbuf_jbi_ue_err,
    output rcv_line_rdy,
    input  rcv_line_vld, rcv_line_ctag, rcv_line_data, rcv_line_ue,
    input  rcv_ovf_err, rcv_proto_err
  );

  modport slave (
    input  scbuf_jbi_ctag_vld, scbuf_jbi_data, scbuf_jbi_ue_err,
    input  rcv_line_rdy,
    output rcv_line_vld, rcv_line_ctag, rcv_line_data, rcv_line_ue,
    output rcv_ovf_err, rcv_proto_err
  );
endinterface

// File: rtl/jbi_rdmard_rcv.sv
// RDMA-read return receiver: frames ctag + NUM_WORDS data words into lines
// and queues them in a 2-entry ping-pong buffer; faults are flagged, not stalled.
module jbi_rdmard_rcv #(
  parameter int NUM_WORDS = 16
) (
  input logic               rclk,
  input logic               arst_l,
  jbi_rdmard_rcv_if.slave   bus
);
  localparam int CW = $clog2(NUM_WORDS);

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    DROP
  } state_t;

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic          r_wr_ptr;
  logic          r_rd_ptr;
  logic [1:0]    r_full;
  logic [14:0]   r_ctag [2];
  logic [1:0]    r_ue;
  logic          r_ovf;
  logic          r_proto;
  logic [31:0]   r_data [2][NUM_WORDS];

  logic w_ctag;
  logic w_vld;
  logic w_pop;
  logic w_free;
  logic w_last;
  logic w_wr_word;

  assign w_ctag    = bus.scbuf_jbi_ctag_vld;
  assign w_vld     = r_full[r_rd_ptr];
  assign w_pop     = w_vld & bus.rcv_line_rdy;
  // the write entry may be reused if it is the one leaving this cycle
  assign w_free    = ~r_full[r_wr_ptr] |
                     (w_pop & (r_rd_ptr == r_wr_ptr));
  assign w_last    = (r_cnt == CW'(NUM_WORDS - 1));
  assign w_wr_word = (r_state == COLLECT) & ~w_ctag;

  always_ff @(posedge rclk or negedge arst_l) begin
    if (!arst_l) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_full   <= '0;
      r_ctag   <= '{default: '0};
      r_ue     <= '0;
      r_ovf    <= 1'b0;
      r_proto  <= 1'b0;
    end else begin
      r_ovf   <= 1'b0;
      r_proto <= 1'b0;
      if (w_ctag) begin
        r_proto <= (r_state != IDLE);
        r_cnt   <= '0;
        if (w_free) begin
          r_state            <= COLLECT;
          r_ctag[r_wr_ptr]   <= bus.scbuf_jbi_data[14:0];
          r_ue[r_wr_ptr]     <= 1'b0;
        end else begin
          r_state <= DROP;
          r_ovf   <= 1'b1;
        end
      end else begin
        case (r_state)
          COLLECT: begin
            r_ue[r_wr_ptr] <= r_ue[r_wr_ptr] |
                              bus.scbuf_jbi_ue_err;
            r_cnt <= r_cnt + CW'(1);
            if (w_last) begin
              r_full[r_wr_ptr] <= 1'b1;
              r_wr_ptr         <= ~r_wr_ptr;
              r_state          <= IDLE;
            end
          end
          DROP: begin
            r_cnt <= r_cnt + CW'(1);
            if (w_last) r_state <= IDLE;
          end
          default: r_state <= IDLE;
        endcase
      end
      // a collecting entry is never full, so this cannot hit the same slot
      if (w_pop) begin
        r_full[r_rd_ptr] <= 1'b0;
        r_rd_ptr         <= ~r_rd_ptr;
      end
    end
  end

  always_ff @(posedge rclk) begin
    if (w_wr_word) r_data[r_wr_ptr][r_cnt] <= bus.scbuf_jbi_data;
  end

  always_comb begin
    bus.rcv_line_data = '0;
    for (int i = 0; i < NUM_WORDS; i++) begin
      bus.rcv_line_data[(NUM_WORDS-1-i)*32 +: 32] =
        w_vld ? r_data[r_rd_ptr][i] : 32'd0;
    end
  end

  assign bus.rcv_line_vld  = w_vld;
  assign bus.rcv_line_ctag = w_vld ? r_ctag[r_rd_ptr] : 15'd0;
  assign bus.rcv_line_ue   = w_vld & r_ue[r_rd_ptr];
  assign bus.rcv_ovf_err   = r_ovf;
  assign bus.rcv_proto_err = r_proto;
endmodule

// File: tb/tb_jbi_rdmard_rcv.sv
// Bench for jbi_rdmard_rcv: queue-based line model, per-cycle compare,
// directed scenarios plus randomized framing, ue and backpressure.
module tb_jbi_rdmard_rcv;
  localparam int NW = 16;

  logic rclk   = 1'b0;
  logic arst_l = 1'b0;

  jbi_rdmard_rcv_if #(.NUM_WORDS(NW)) bus ();

  jbi_rdmard_rcv #(.NUM_WORDS(NW)) dut (
    .rclk   (rclk),
    .arst_l (arst_l),
    .bus    (bus)
  );

  always #5 rclk = ~rclk;

  typedef struct packed {
    logic [14:0]      ctag;
    logic [32*NW-1:0] data;
    logic             ue;
  } line_t;

  int total = 0;
  int bad   = 0;
  int n_ovf = 0;
  int n_proto = 0;

  line_t       q[$];
  logic [14:0] log_q[$];
  int          mode = 0;
  int          cnt  = 0;
  line_t       cur;
  bit          e_ovf = 0;
  bit          e_proto = 0;
  bit          m_pop;
  bit          m_push;

  task automatic chk(input string nm, input logic [32*NW-1:0] act,
                     input logic [32*NW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    end
  endtask

  // model: a line is a ctag plus NW words; queue holds at most two
  always @(posedge rclk or negedge arst_l) begin
    if (!arst_l) begin
      q.delete();
      mode = 0;
      cnt = 0;
      e_ovf = 0;
      e_proto = 0;
    end else begin
      m_pop = (q.size() > 0) && bus.rcv_line_rdy;
      m_push = 0;
      e_ovf = 0;
      e_proto = 0;
      if (bus.scbuf_jbi_ctag_vld) begin
        if (mode != 0) e_proto = 1;
        cnt = 0;
        if (q.size() < 2 || m_pop) begin
          mode = 1;
          cur.ctag = bus.scbuf_jbi_data[14:0];
          cur.ue = 0;
          cur.data = '0;
        end else begin
          mode = 2;
          e_ovf = 1;
        end
      end else if (mode == 1) begin
        cur.data[(NW-1-cnt)*32 +: 32] = bus.scbuf_jbi_data;
        cur.ue = cur.ue | bus.scbuf_jbi_ue_err;
        cnt++;
        if (cnt == NW) begin
          m_push = 1;
          mode = 0;
        end
      end else if (mode == 2) begin
        cnt++;
        if (cnt == NW) mode = 0;
      end
      if (m_pop) begin
        log_q.push_back(q[0].ctag);
        void'(q.pop_front());
      end
      if (m_push) q.push_back(cur);
    end
  end

  always @(negedge rclk) begin
    if (bus.rcv_ovf_err) n_ovf++;
    if (bus.rcv_proto_err) n_proto++;
    chk("vld", 512'(bus.rcv_line_vld), 512'(q.size() > 0));
    chk("ovf", 512'(bus.rcv_ovf_err), 512'(e_ovf));
    chk("proto", 512'(bus.rcv_proto_err), 512'(e_proto));
    if (q.size() > 0) begin
      chk("ctag", 512'(bus.rcv_line_ctag), 512'(q[0].ctag));
      chk("data", bus.rcv_line_data, q[0].data);
      chk("ue", 512'(bus.rcv_line_ue), 512'(q[0].ue));
    end else begin
      chk("ctag0", 512'(bus.rcv_line_ctag), 512'd0);
      chk("data0", bus.rcv_line_data, 512'd0);
      chk("ue0", 512'(bus.rcv_line_ue), 512'd0);
    end
  end

  // r: 0/1 set rdy, 2 keep, 3 random
  task automatic drive(input logic c, input logic [31:0] d,
                       input logic u, input int r);
    @(negedge rclk);
    #1;
    bus.scbuf_jbi_ctag_vld = c;
    bus.scbuf_jbi_data = d;
    bus.scbuf_jbi_ue_err = u;
    if (r == 0) bus.rcv_line_rdy = 1'b0;
    else if (r == 1) bus.rcv_line_rdy = 1'b1;
    else if (r == 3) bus.rcv_line_rdy = ($urandom % 3) != 0;
  endtask

  task automatic send_line(input logic [14:0] c, input logic [31:0] base,
                           input int ue_at, input int n,
                           input int rc, input int rw);
    drive(1'b1, {17'h1abcd, c}, 1'b1, rc);
    for (int i = 0; i < n; i++)
      drive(1'b0, base + 32'(i), (i == ue_at), rw);
  endtask

  task automatic idle(input int n, input int r);
    for (int i = 0; i < n; i++) drive(1'b0, $urandom, 1'b1, r);
  endtask

  int ovf0, proto0;
  logic [32*NW-1:0] d;

  initial begin
    bus.scbuf_jbi_ctag_vld = 1'b0;
    bus.scbuf_jbi_data = '0;
    bus.scbuf_jbi_ue_err = 1'b0;
    bus.rcv_line_rdy = 1'b0;
    repeat (3) @(negedge rclk);
    chk("rst_vld", 512'(bus.rcv_line_vld), 512'd0);
    #1 arst_l = 1'b1;

    // 1: basic line
    send_line(15'h1A5B, 32'h1000_0000, -1, NW, 1, 1);
    @(negedge rclk);
    d = bus.rcv_line_data;
    chk("t1_vld", 512'(bus.rcv_line_vld), 512'd1);
    chk("t1_ctag", 512'(bus.rcv_line_ctag), 512'(15'h1A5B));
    chk("t1_w0", 512'(d[511:480]), 512'(32'h1000_0000));
    chk("t1_w15", 512'(d[31:0]), 512'(32'h1000_000F));
    chk("t1_ue", 512'(bus.rcv_line_ue), 512'd0);
    idle(2, 1);

    // 2: ue on word 7 only, then clean line
    send_line(15'h0777, 32'h2000_0000, 7, NW, 1, 1);
    @(negedge rclk);
    chk("t2_ue1", 512'(bus.rcv_line_ue), 512'd1);
    send_line(15'h0778, 32'h2100_0000, -1, NW, 1, 1);
    @(negedge rclk);
    chk("t2_ue2", 512'(bus.rcv_line_ue), 512'd0);
    idle(2, 1);

    // 3: overflow with consumer stalled
    log_q.delete();
    ovf0 = n_ovf;
    send_line(15'h0301, 32'h3100_0000, -1, NW, 0, 0);
    send_line(15'h0302, 32'h3200_0000, -1, NW, 0, 0);
    send_line(15'h0303, 32'h3300_0000, -1, NW, 0, 0);
    idle(2, 0);
    chk("t3_ovf", 512'(n_ovf - ovf0), 512'd1);
    idle(6, 1);
    chk("t3_n", 512'(log_q.size()), 512'd2);
    chk("t3_l1", 512'(log_q[0]), 512'(15'h0301));
    chk("t3_l2", 512'(log_q[1]), 512'(15'h0302));

    // 4: pop on the third ctag cycle frees an entry
    log_q.delete();
    ovf0 = n_ovf;
    send_line(15'h0401, 32'h4100_0000, -1, NW, 0, 0);
    send_line(15'h0402, 32'h4200_0000, -1, NW, 0, 0);
    send_line(15'h0403, 32'h4300_0000, -1, NW, 1, 1);
    idle(4, 1);
    chk("t4_ovf", 512'(n_ovf - ovf0), 512'd0);
    chk("t4_n", 512'(log_q.size()), 512'd3);
    chk("t4_l3", 512'(log_q[2]), 512'(15'h0403));

    // 5: ctag mid-line
    log_q.delete();
    proto0 = n_proto;
    send_line(15'h0011, 32'h5100_0000, -1, 5, 1, 1);
    send_line(15'h0022, 32'h5200_0000, -1, NW, 1, 1);
    @(negedge rclk);
    d = bus.rcv_line_data;
    chk("t5_ctag", 512'(bus.rcv_line_ctag), 512'(15'h0022));
    chk("t5_w0", 512'(d[511:480]), 512'(32'h5200_0000));
    idle(3, 1);
    chk("t5_proto", 512'(n_proto - proto0), 512'd1);
    chk("t5_n", 512'(log_q.size()), 512'd1);

    // 6: reset mid-line with a line queued
    ovf0 = n_ovf;
    proto0 = n_proto;
    send_line(15'h0601, 32'h6100_0000, -1, NW, 0, 0);
    send_line(15'h0602, 32'h6200_0000, -1, 9, 0, 0);
    #2 arst_l = 1'b0;
    drive(1'b0, 32'h0, 1'b0, 0);
    chk("t6_vld", 512'(bus.rcv_line_vld), 512'd0);
    chk("t6_data", bus.rcv_line_data, 512'd0);
    drive(1'b0, 32'h0, 1'b0, 0);
    arst_l = 1'b1;
    send_line(15'h0603, 32'h6300_0000, -1, NW, 1, 1);
    @(negedge rclk);
    chk("t6_ctag", 512'(bus.rcv_line_ctag), 512'(15'h0603));
    idle(2, 1);
    chk("t6_err", 512'(n_ovf - ovf0 + n_proto - proto0), 512'd0);

    // random framing, ue and backpressure
    for (int k = 0; k < 150; k++) begin
      idle($urandom_range(0, 3), 3);
      send_line(15'($urandom),
                $urandom,
                ($urandom % 4 == 0) ? int'($urandom_range(0, NW-1)) : -1,
                ($urandom % 8 == 0) ? int'($urandom_range(1, NW-1)) : NW,
                3, 3);
    end
    idle(20, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
